// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the integer pipeline.
//   XLEN / REG_AW : datapath width and register index width
//   alu_op_e      : ALU operation class from decode
//   a_sel_e       : operand-A source select
//   id_ex_t       : every field held in the ID/EX pipeline register
//   fix_funct7    : funct7 clean-up applied when an instruction enters EX
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_OR    = 2'b11
    } alu_op_e;

    // 2'b11 is an alias for RS1 so the decoder can leave a_sel[1:0] loosely encoded.
    typedef enum logic [1:0] {
        A_RS1     = 2'b00,
        A_PC      = 2'b01,
        A_ZERO    = 2'b10,
        A_RS1_ALT = 2'b11
    } a_sel_e;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        alu_op_e           alu_op;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        a_sel_e            a_sel;
        logic              b_imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } id_ex_t;

    // OP-IMM instructions other than the right shifts carry immediate bits in
    // instr[31:25]; clearing them keeps e.g. ADDI with imm[10]=1 from decoding as SUB.
    function automatic logic [6:0] fix_funct7(input logic       is_itype,
                                              input logic [2:0] funct3,
                                              input logic [6:0] funct7);
        return (is_itype && (funct3 != 3'b101)) ? 7'd0 : funct7;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// ----------------------------------------------------------------------------
// fwd_mux
// Selects the freshest value of one source register for the EX stage.
//   src_idx       : register index the EX instruction reads
//   rf_data       : value read from the regfile during decode
//   exm_*         : result of the instruction currently in EX/MEM (newest)
//   mwb_*         : result of the instruction currently in MEM/WB
//   value         : forwarded operand
// ----------------------------------------------------------------------------
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] src_idx,
    input  logic [XLEN-1:0]   rf_data,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_reg_write,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic              mwb_reg_write,
    input  logic [XLEN-1:0]   mwb_result,
    output logic [XLEN-1:0]   value
);

    logic hit_exm;
    logic hit_mwb;

    // x0 is hard-wired to zero, so a write "to" it must never be forwarded.
    assign hit_exm = exm_reg_write && (exm_rd != '0) && (exm_rd == src_idx);
    assign hit_mwb = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == src_idx);

    // EX/MEM is checked first: it holds the younger of the two producers.
    assign value = hit_exm ? exm_result :
                   hit_mwb ? mwb_result :
                             rf_data;

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with EX-side operand forwarding and load-use
// hazard detection.
//   clk, rst                 : rising-edge clock, synchronous active-high reset
//   id_*                     : decoded instruction and regfile read data
//   flush                    : squash the instruction entering EX
//   exm_* / mwb_*            : forwarding sources from EX/MEM and MEM/WB
//   stall_id                 : hold PC and IF/ID (load-use hazard)
//   ex_valid, ex_a, ex_b     : real-instruction flag and final ALU operands
//   ex_alu_op/funct3/funct7  : ALU control
//   ex_store_data            : forwarded rs2 for stores
//   ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg : control
// ----------------------------------------------------------------------------
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_alu_op,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              id_is_itype,
    input  logic [1:0]        id_a_sel,
    input  logic              id_b_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              flush,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_reg_write,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic              mwb_reg_write,
    input  logic [XLEN-1:0]   mwb_result,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_a,
    output logic [XLEN-1:0]   ex_b,
    output logic [1:0]        ex_alu_op,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    logic            load_use;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    // ------------------------------------------------------------------
    // Load-use hazard: the load in EX has no data until MEM, so a dependent
    // instruction in ID must wait one cycle. A flush kills that instruction
    // anyway, so there is nothing to stall for.
    // ------------------------------------------------------------------
    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_q.rd))) &&
                      id_valid && !flush;

    assign stall_id = load_use && !rst;

    // ------------------------------------------------------------------
    // Next-state of the pipeline register
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning the whole struct first means every path drives every bit, so no latch is inferred.
        ex_d = '0;
        if (!(flush || load_use)) begin
            ex_d.valid      = id_valid;
            ex_d.pc         = id_pc;
            ex_d.rs1_data   = id_rs1_data;
            ex_d.rs2_data   = id_rs2_data;
            ex_d.imm        = id_imm;
            ex_d.rs1        = id_rs1;
            ex_d.rs2        = id_rs2;
            ex_d.rd         = id_rd;
            ex_d.alu_op     = alu_op_e'(id_alu_op);
            ex_d.funct3     = id_funct3;
            ex_d.funct7     = fix_funct7(id_is_itype, id_funct3, id_funct7);
            ex_d.a_sel      = a_sel_e'(id_a_sel);
            ex_d.b_imm      = id_b_imm;
            // A decode slot without a real instruction must never enable a write.
            ex_d.reg_write  = id_reg_write  && id_valid;
            ex_d.mem_read   = id_mem_read   && id_valid;
            ex_d.mem_write  = id_mem_write  && id_valid;
            ex_d.mem_to_reg = id_mem_to_reg && id_valid;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every register samples pre-edge values regardless of block order.
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding on the registered source indices
    // ------------------------------------------------------------------
    fwd_mux u_fwd_rs1 (
        .src_idx       (ex_q.rs1),
        .rf_data       (ex_q.rs1_data),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .mwb_rd        (mwb_rd),
        .mwb_reg_write (mwb_reg_write),
        .mwb_result    (mwb_result),
        .value         (rs1_fwd)
    );

    fwd_mux u_fwd_rs2 (
        .src_idx       (ex_q.rs2),
        .rf_data       (ex_q.rs2_data),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .mwb_rd        (mwb_rd),
        .mwb_reg_write (mwb_reg_write),
        .mwb_result    (mwb_result),
        .value         (rs2_fwd)
    );

    // ------------------------------------------------------------------
    // Operand selection and outputs
    // ------------------------------------------------------------------
    always_comb begin
        ex_a = rs1_fwd;
        case (ex_q.a_sel)
            A_PC:    ex_a = ex_q.pc;
            A_ZERO:  ex_a = '0;
            default: ex_a = rs1_fwd;
        endcase
    end

    assign ex_b          = ex_q.b_imm ? ex_q.imm : rs2_fwd;
    assign ex_store_data = rs2_fwd;

    assign ex_valid      = ex_q.valid;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_funct3     = ex_q.funct3;
    assign ex_funct7     = ex_q.funct7;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Scoreboard bench for id_ex_stage: the stimulus process predicts what the
// EX-side outputs must be each cycle and queues it; a negedge monitor pops
// and compares. Directed scenarios first, then randomized traffic.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic [1:0]  id_alu_op, id_a_sel;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        id_is_itype, id_b_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        flush;
    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_reg_write, mwb_reg_write;
    logic [31:0] exm_result, mwb_result;
    logic        stall_id, ex_valid;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [1:0]  ex_alu_op;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_is_itype(id_is_itype), .id_a_sel(id_a_sel), .id_b_imm(id_b_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .flush(flush),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    // One cycle of input stimulus.
    typedef struct {
        logic        rst, flush, v;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [1:0]  op, asel;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        itype, bimm, rw, mr, mw, m2r;
        logic [4:0]  exm_rd, mwb_rd;
        logic        exm_rw, mwb_rw;
        logic [31:0] exm_res, mwb_res;
    } stim_t;

    // What the model believes is sitting in the EX stage.
    typedef struct {
        logic        v;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  op, asel;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        bimm, rw, mr, mw, m2r;
    } slot_t;

    typedef struct {
        logic        valid, stall;
        logic [31:0] a, b, sd;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r;
    } exp_t;

    exp_t  exp_q[$];
    slot_t m;
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{v: 1'b0, pc: '0, r1d: '0, r2d: '0, imm: '0, rs1: '0, rs2: '0, rd: '0,
              op: '0, asel: '0, f3: '0, f7: '0, bimm: 1'b0, rw: 1'b0, mr: 1'b0,
              mw: 1'b0, m2r: 1'b0};
        return s;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{rst: 1'b0, flush: 1'b0, v: 1'b0, pc: '0, r1d: '0, r2d: '0, imm: '0,
              rs1: '0, rs2: '0, rd: '0, u1: 1'b0, u2: 1'b0, op: '0, asel: '0,
              f3: '0, f7: '0, itype: 1'b0, bimm: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0,
              m2r: 1'b0, exm_rd: '0, mwb_rd: '0, exm_rw: 1'b0, mwb_rw: 1'b0,
              exm_res: '0, mwb_res: '0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s        = nop();
        s.rst    = ($urandom_range(0, 59) == 0);
        s.flush  = ($urandom_range(0, 9) == 0);
        s.v      = ($urandom_range(0, 5) != 0);
        s.pc     = $urandom;  s.r1d = $urandom;  s.r2d = $urandom;  s.imm = $urandom;
        s.rs1    = 5'($urandom_range(0, 7));
        s.rs2    = 5'($urandom_range(0, 7));
        s.rd     = 5'($urandom_range(0, 7));
        s.u1     = ($urandom_range(0, 3) != 0);
        s.u2     = ($urandom_range(0, 1) != 0);
        s.op     = 2'($urandom);
        s.asel   = 2'($urandom);
        s.f3     = 3'($urandom);
        s.f7     = 7'($urandom);
        s.itype  = 1'($urandom);
        s.bimm   = 1'($urandom);
        s.rw     = 1'($urandom);
        s.mr     = ($urandom_range(0, 2) == 0);
        s.mw     = 1'($urandom);
        s.m2r    = 1'($urandom);
        s.exm_rd = 5'($urandom_range(0, 7));
        s.mwb_rd = 5'($urandom_range(0, 7));
        s.exm_rw = 1'($urandom);
        s.mwb_rw = 1'($urandom);
        s.exm_res = $urandom;
        s.mwb_res = $urandom;
        return s;
    endfunction

    // Newest architectural value of register r as seen by EX this cycle.
    function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf, input stim_t s);
        if (r == 5'd0)                     return rf;
        if (s.exm_rw && s.exm_rd == r)     return s.exm_res;
        if (s.mwb_rw && s.mwb_rd == r)     return s.mwb_res;
        return rf;
    endfunction

    task automatic drive(input stim_t s);
        rst = s.rst;  flush = s.flush;  id_valid = s.v;
        id_pc = s.pc;  id_rs1_data = s.r1d;  id_rs2_data = s.r2d;  id_imm = s.imm;
        id_rs1 = s.rs1;  id_rs2 = s.rs2;  id_rd = s.rd;
        id_uses_rs1 = s.u1;  id_uses_rs2 = s.u2;
        id_alu_op = s.op;  id_a_sel = s.asel;  id_funct3 = s.f3;  id_funct7 = s.f7;
        id_is_itype = s.itype;  id_b_imm = s.bimm;
        id_reg_write = s.rw;  id_mem_read = s.mr;  id_mem_write = s.mw;  id_mem_to_reg = s.m2r;
        exm_rd = s.exm_rd;  exm_reg_write = s.exm_rw;  exm_result = s.exm_res;
        mwb_rd = s.mwb_rd;  mwb_reg_write = s.mwb_rw;  mwb_result = s.mwb_res;
    endtask

    // Drive one cycle, predict this cycle's outputs, then advance the model.
    task automatic issue(input stim_t s);
        exp_t        e;
        logic        dep;
        logic [31:0] v1, v2;
        @(posedge clk);
        #1;
        drive(s);

        v1 = reg_value(m.rs1, m.r1d, s);
        v2 = reg_value(m.rs2, m.r2d, s);
        // Dependent on a load still in EX: its data does not exist yet.
        dep = m.v && m.mr && (m.rd != 5'd0) && s.v &&
              ((s.u1 && s.rs1 == m.rd) || (s.u2 && s.rs2 == m.rd));

        e.valid = m.v;
        e.stall = dep && !s.flush && !s.rst;
        e.a     = (m.asel == 2'b01) ? m.pc : (m.asel == 2'b10) ? 32'd0 : v1;
        e.b     = m.bimm ? m.imm : v2;
        e.sd    = v2;
        e.op = m.op;  e.f3 = m.f3;  e.f7 = m.f7;  e.rd = m.rd;
        e.rw = m.rw;  e.mr = m.mr;  e.mw = m.mw;  e.m2r = m.m2r;
        exp_q.push_back(e);

        if (s.rst || s.flush || dep) begin
            m = empty_slot();
        end else begin
            m.v = s.v;  m.pc = s.pc;  m.r1d = s.r1d;  m.r2d = s.r2d;  m.imm = s.imm;
            m.rs1 = s.rs1;  m.rs2 = s.rs2;  m.rd = s.rd;  m.op = s.op;  m.asel = s.asel;
            m.f3 = s.f3;  m.bimm = s.bimm;
            // Only OP-IMM right shifts carry a real funct7.
            m.f7  = (s.itype && s.f3 != 3'd5) ? 7'd0 : s.f7;
            m.rw  = s.rw  & s.v;
            m.mr  = s.mr  & s.v;
            m.mw  = s.mw  & s.v;
            m.m2r = s.m2r & s.v;
        end
    endtask

    // Monitor: compares the DUT against the oldest prediction, mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ex_valid",      32'(ex_valid),      32'(e.valid));
            check("stall_id",      32'(stall_id),      32'(e.stall));
            check("ex_reg_write",  32'(ex_reg_write),  32'(e.rw));
            check("ex_mem_read",   32'(ex_mem_read),   32'(e.mr));
            check("ex_mem_write",  32'(ex_mem_write),  32'(e.mw));
            check("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(e.m2r));
            if (e.valid) begin
                check("ex_a",          ex_a,              e.a);
                check("ex_b",          ex_b,              e.b);
                check("ex_store_data", ex_store_data,     e.sd);
                check("ex_alu_op",     32'(ex_alu_op),    32'(e.op));
                check("ex_funct3",     32'(ex_funct3),    32'(e.f3));
                check("ex_funct7",     32'(ex_funct7),    32'(e.f7));
                check("ex_rd",         32'(ex_rd),        32'(e.rd));
            end
        end
    end

    initial begin
        stim_t s;
        m = empty_slot();

        // Bring the register out of its power-up state before predicting anything.
        s = nop();  s.rst = 1'b1;
        drive(s);
        @(posedge clk);
        issue(s);                               // reset state observed

        // 1: add x3,x1,x2 ; sub x4,x3,x1 with add's result on EX/MEM.
        s = nop();  s.v = 1;  s.rs1 = 1;  s.rs2 = 2;  s.u1 = 1;  s.u2 = 1;  s.rd = 3;
        s.rw = 1;  s.r1d = 32'h5;  s.r2d = 32'hB;  s.pc = 32'h100;
        issue(s);
        s = nop();  s.v = 1;  s.rs1 = 3;  s.rs2 = 1;  s.u1 = 1;  s.u2 = 1;  s.rd = 4;
        s.op = 2'b01;  s.rw = 1;  s.r1d = 32'hDEAD;  s.r2d = 32'h5;  s.pc = 32'h104;
        issue(s);
        s = nop();  s.exm_rd = 3;  s.exm_rw = 1;  s.exm_res = 32'h10;
        issue(s);

        // 2: both stages write x5, EX/MEM wins; then exm_rd=0 is never forwarded.
        s = nop();  s.v = 1;  s.rs1 = 5;  s.u1 = 1;  s.rd = 7;  s.rw = 1;  s.r1d = 32'h55;
        issue(s);
        s = nop();  s.v = 1;  s.rs1 = 0;  s.rs2 = 0;  s.u1 = 1;  s.rd = 8;  s.rw = 1;
        s.r1d = 32'h33;  s.r2d = 32'h44;
        s.exm_rd = 5;  s.exm_rw = 1;  s.exm_res = 32'hAA;
        s.mwb_rd = 5;  s.mwb_rw = 1;  s.mwb_res = 32'hBB;
        issue(s);
        s = nop();  s.exm_rd = 0;  s.exm_rw = 1;  s.exm_res = 32'hAA;
        s.mwb_rd = 0;  s.mwb_rw = 1;  s.mwb_res = 32'hBB;
        issue(s);

        // 3: lw x6 then dependent add -> one stall, bubble, then captured.
        s = nop();  s.v = 1;  s.rs1 = 1;  s.u1 = 1;  s.rd = 6;  s.rw = 1;  s.mr = 1;
        s.m2r = 1;  s.bimm = 1;  s.imm = 32'h8;
        issue(s);
        s = nop();  s.v = 1;  s.rs1 = 6;  s.rs2 = 2;  s.u1 = 1;  s.u2 = 1;  s.rd = 7;
        s.rw = 1;  s.r1d = 32'h66;  s.r2d = 32'h22;
        issue(s);                               // stall_id expected high
        issue(s);                               // held instruction now enters EX
        s = nop();  s.mwb_rd = 6;  s.mwb_rw = 1;  s.mwb_res = 32'h1234;
        issue(s);

        // 4: load-use coinciding with flush -> no stall, instruction dropped.
        s = nop();  s.v = 1;  s.rs1 = 1;  s.u1 = 1;  s.rd = 6;  s.rw = 1;  s.mr = 1;
        issue(s);
        s = nop();  s.v = 1;  s.rs1 = 6;  s.u1 = 1;  s.rd = 9;  s.rw = 1;  s.flush = 1;
        issue(s);
        issue(nop());

        // 5: ADDI with imm[10]=1 clears funct7; SRAI keeps it.
        s = nop();  s.v = 1;  s.itype = 1;  s.f3 = 3'b000;  s.f7 = 7'h20;  s.bimm = 1;
        s.imm = 32'h400;  s.rs1 = 1;  s.u1 = 1;  s.rd = 10;  s.rw = 1;  s.op = 2'b10;
        issue(s);
        s.f3 = 3'b101;  s.imm = 32'h403;  s.rd = 11;
        issue(s);
        issue(nop());

        // 6: reset while valid instructions keep arriving.
        s = nop();  s.v = 1;  s.rd = 12;  s.rw = 1;  s.mw = 1;
        issue(s);
        s.rst = 1;  s.mr = 1;
        issue(s);
        s.rst = 0;  s.mr = 0;
        issue(s);
        issue(nop());

        // Randomized traffic with a narrow register range to provoke hazards.
        for (int i = 0; i < 600; i++) issue(rand_stim());
        issue(nop());

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
